fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
//  Front end of the RV32I core: combined instruction fetch and decode.
//  Drives the fetch port from the core PC and returns the fetched word.
//  Fully decodes RV32I fields and sign-extended immediate, and flags illegal or all-zero words.
//  Keeps a sticky halt flag; the core uses o_valid/o_halted to advance or stop its PC.
// PARAMETERS
//  ADDR_WIDTH  31  MSB index of fetch address bus (bus is ADDR_WIDTH+1 bits)
//  DATA_WIDTH  31  MSB index of fetch data bus (>=31; only bits [31:0] decoded)
// PORTS
//  clk                input   1             clock; all state on rising edge
//  rst                input   1             reset, synchronous, active-high
//  clk_en             input   1             stage enable; state updates only when 1
//  i_pc               input   32            word-addressed PC (core adds 1 per instruction)
//  o_read_fetch_addr  output  ADDR_WIDTH+1  fetch address to instruction RAM
//  i_read_fetch_data  input   DATA_WIDTH+1  fetched word (same-cycle/async read)
//  o_instruction      output  32            fetched instruction
//  o_valid            output  1             1 = legal, non-zero RV32I instruction
//  o_opcode           output  7             instr[6:0]
//  o_rd/o_rs1/o_rs2   output  5 each        instr[11:7] / [19:15] / [24:20]
//  o_funct3           output  3             instr[14:12]
//  o_funct7           output  7             instr[31:25]
//  o_imm_type         output  3             0 none(R/SYSTEM/FENCE), 1 I, 2 S, 3 B, 4 U, 5 J
//  o_imm              output  32            sign-extended immediate; 0 when type none
//  o_halted           output  1             sticky: an invalid word was seen with clk_en=1
// BEHAVIOUR
//  Fetch (combinational, zero latency):
//  - o_read_fetch_addr = i_pc[ADDR_WIDTH:0].
//  - o_instruction = i_read_fetch_data[31:0]; forced to 0 while rst=1.
//  Field decode (combinational): outputs are slices of o_instruction.
//  Immediates:
//  - I = {{20{i[31]}},i[31:20]}.
//  - S = {{20{i[31]}},i[31:25],i[11:7]}.
//  - B = {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}.
//  - U = {i[31:12],12'b0}.
//  - J = {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
//  o_valid = 1 only if the word is non-zero, instr[1:0]==2'b11, and one of:
//  - LUI 0110111, AUIPC 0010111 (type U); JAL 1101111 (type J).
//  - JALR 1100111 with f3=000 (type I).
//  - BRANCH 1100011 with f3 in {000,001,100,101,110,111} (type B).
//  - LOAD 0000011 with f3 in {000,001,010,100,101} (type I).
//  - STORE 0100011 with f3 in {000,001,010} (type S).
//  - OP-IMM 0010011 (type I):
//    - f3=001 needs f7=0000000.
//    - f3=101 needs f7 in {0000000,0100000}.
//    - other f3 unconstrained.
//  - OP 0110011 (type none):
//    - f7=0000000 with any f3.
//    - f7=0100000 only with f3 in {000,101}.
//  - MISC-MEM 0001111 with f3=000 (FENCE, type none).
//  - SYSTEM: exactly 32'h00000073 (ECALL) or 32'h00100073 (EBREAK), type none.
//  - Anything else gives o_valid=0.
//  Invalid words:
//  - o_imm_type and o_imm still follow the opcode table.
//  - An unknown opcode gives type none and o_imm=0.
//  o_halted (registered):
//  - rst -> 0.
//  - Else if clk_en && !o_valid -> 1.
//  - Holds at 1 until rst.
//  - clk_en=0 freezes it.
//  Reset values: o_halted=0; o_instruction=0, hence o_valid=0 and all fields 0, for every cycle rst=1.
//  Reset mid-run clears o_halted on the next edge regardless of clk_en.
//  No handshake: data must be valid in the same cycle as the address.
// TESTING
//  1. pc=5, data=32'h00500093 (addi x1,x0,5) -> addr=5, valid=1, rd=1, rs1=0, imm_type=1, imm=5.
//  2. data=32'hFE000EE3 (beq x0,x0,-4) -> valid=1, imm_type=3, imm=32'hFFFFFFFC.
//  3. data=32'h40000033 (sub) -> valid=1; 32'h40001033 -> valid=0.
//  4. data=0 with clk_en=1 -> valid=0; halted=1 next edge; stays 1 with valid data; rst -> 0.
//  5. data=32'h00100073 -> valid=1; data=32'h00200073 -> valid=0.
//  6. data=32'h800000EF (jal x1,-1MiB) -> imm=32'hFFF00000, imm_type=5.
//  7. Hold rst=1 -> o_instruction=0, o_valid=0.
//  8. clk_en=0 with invalid word -> halted unchanged.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// RV32I front end: zero-latency fetch, full field/immediate decode,
// legality check and a sticky halt flag for the core's PC control.
module fetch_decode_unit #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [31:0]           i_pc,
  output logic [ADDR_WIDTH:0]   o_read_fetch_addr,
  input  logic [DATA_WIDTH:0]   i_read_fetch_data,
  output logic [31:0]           o_instruction,
  output logic                  o_valid,
  output logic [6:0]            o_opcode,
  output logic [4:0]            o_rd,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic [2:0]            o_funct3,
  output logic [6:0]            o_funct7,
  output logic [2:0]            o_imm_type,
  output logic [31:0]           o_imm,
  output logic                  o_halted
);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] instr;
  logic        legal;
  logic        halted_d, halted_q;

  // Fetch path: PC straight to the RAM, word back the same cycle; reset blanks it.
  always_comb begin
    o_read_fetch_addr = i_pc[ADDR_WIDTH:0];
    instr             = rst ? 32'h0 : i_read_fetch_data[31:0];
  end

  // Field slices of the fetched word.
  always_comb begin
    o_instruction = instr;
    o_opcode      = instr[6:0];
    o_rd          = instr[11:7];
    o_funct3      = instr[14:12];
    o_rs1         = instr[19:15];
    o_rs2         = instr[24:20];
    o_funct7      = instr[31:25];
  end

  // Opcode table: immediate format always follows the opcode, legality also checks funct fields.
  always_comb begin
    o_imm_type = IMM_NONE;
    legal      = 1'b0;
    unique case (o_opcode)
      OP_LUI, OP_AUIPC: begin o_imm_type = IMM_U; legal = 1'b1; end
      OP_JAL:           begin o_imm_type = IMM_J; legal = 1'b1; end
      OP_JALR:          begin o_imm_type = IMM_I; legal = (o_funct3 == 3'b000); end
      OP_BRANCH: begin
        o_imm_type = IMM_B;
        legal      = (o_funct3 != 3'b010) && (o_funct3 != 3'b011);
      end
      OP_LOAD: begin
        o_imm_type = IMM_I;
        legal      = (o_funct3 != 3'b011) && (o_funct3 != 3'b110) && (o_funct3 != 3'b111);
      end
      OP_STORE: begin o_imm_type = IMM_S; legal = (o_funct3 <= 3'b010); end
      OP_IMM: begin
        o_imm_type = IMM_I;
        if (o_funct3 == 3'b001)      legal = (o_funct7 == 7'b0000000);
        else if (o_funct3 == 3'b101) legal = (o_funct7 == 7'b0000000) || (o_funct7 == 7'b0100000);
        else                         legal = 1'b1;
      end
      OP_OP: begin
        legal = (o_funct7 == 7'b0000000) ||
                ((o_funct7 == 7'b0100000) && ((o_funct3 == 3'b000) || (o_funct3 == 3'b101)));
      end
      OP_MISC:   legal = (o_funct3 == 3'b000);
      OP_SYSTEM: legal = (instr == 32'h00000073) || (instr == 32'h00100073);
      default: begin
        o_imm_type = IMM_NONE;
        legal      = 1'b0;
      end
    endcase
    // Low-bit and zero checks are implied by the table but kept explicit for clarity.
    o_valid = legal && (instr != 32'h0) && (instr[1:0] == 2'b11);
  end

  // Sign-extended immediate assembled according to the decoded format.
  always_comb begin
    unique case (o_imm_type)
      IMM_I:   o_imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   o_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   o_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   o_imm = {instr[31:12], 12'b0};
      IMM_J:   o_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: o_imm = 32'h0;
    endcase
  end

  // Sticky halt: set by any enabled invalid word, cleared only by reset.
  always_comb begin
    halted_d = halted_q;
    if (rst)                     halted_d = 1'b0;
    else if (clk_en && !o_valid) halted_d = 1'b1;
  end

  // Halt flag register.
  always_ff @(posedge clk) begin
    halted_q <= halted_d;
  end

  assign o_halted = halted_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: decode table plus halt/reset sequences.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] i_pc;
  logic [31:0] o_read_fetch_addr;
  logic [31:0] i_read_fetch_data;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic [6:0]  o_opcode;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3;
  logic [6:0]  o_funct7;
  logic [2:0]  o_imm_type;
  logic [31:0] o_imm;
  logic        o_halted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_decode_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_pc(i_pc),
    .o_read_fetch_addr(o_read_fetch_addr), .i_read_fetch_data(i_read_fetch_data),
    .o_instruction(o_instruction), .o_valid(o_valid), .o_opcode(o_opcode),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3), .o_funct7(o_funct7),
    .o_imm_type(o_imm_type), .o_imm(o_imm), .o_halted(o_halted)
  );

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic [2:0]  itype;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            data          valid itype imm           rd
    vecs[0]  = '{32'h00500093, 1'b1, 3'd1, 32'h00000005, 5'd1};   // addi x1,x0,5
    vecs[1]  = '{32'hFE000EE3, 1'b1, 3'd3, 32'hFFFFFFFC, 5'd29};  // beq -4
    vecs[2]  = '{32'h40000033, 1'b1, 3'd0, 32'h00000000, 5'd0};   // sub
    vecs[3]  = '{32'h40001033, 1'b0, 3'd0, 32'h00000000, 5'd0};   // f7=0100000 f3=001
    vecs[4]  = '{32'h00100073, 1'b1, 3'd0, 32'h00000000, 5'd0};   // ebreak
    vecs[5]  = '{32'h00200073, 1'b0, 3'd0, 32'h00000000, 5'd0};   // bad system
    vecs[6]  = '{32'h800000EF, 1'b1, 3'd5, 32'hFFF00000, 5'd1};   // jal -1MiB
    vecs[7]  = '{32'h00000000, 1'b0, 3'd0, 32'h00000000, 5'd0};   // all zero
    vecs[8]  = '{32'h123452B7, 1'b1, 3'd4, 32'h12345000, 5'd5};   // lui
    vecs[9]  = '{32'hFE20AC23, 1'b1, 3'd2, 32'hFFFFFFF8, 5'd24};  // sw -8
    vecs[10] = '{32'hFE20BC23, 1'b0, 3'd2, 32'hFFFFFFF8, 5'd24};  // store f3=011
    vecs[11] = '{32'h40309093, 1'b0, 3'd1, 32'h00000403, 5'd1};   // slli bad f7
    vecs[12] = '{32'h4030D093, 1'b1, 3'd1, 32'h00000403, 5'd1};   // srai
    vecs[13] = '{32'h00002083, 1'b1, 3'd1, 32'h00000000, 5'd1};   // lw
    vecs[14] = '{32'h00003083, 1'b0, 3'd1, 32'h00000000, 5'd1};   // load f3=011
    vecs[15] = '{32'h004100E7, 1'b1, 3'd1, 32'h00000004, 5'd1};   // jalr
    vecs[16] = '{32'h004110E7, 1'b0, 3'd1, 32'h00000004, 5'd1};   // jalr f3=001
    vecs[17] = '{32'hFFFFFFFF, 1'b0, 3'd0, 32'h00000000, 5'd31};  // unknown opcode
    vecs[18] = '{32'h0FF0000F, 1'b1, 3'd0, 32'h00000000, 5'd0};   // fence
    vecs[19] = '{32'hFE002EE3, 1'b0, 3'd3, 32'hFFFFFFFC, 5'd29};  // branch f3=010

    // Reset: word forced to zero, halt cleared.
    rst = 1'b1; clk_en = 1'b1; i_pc = 32'd0; i_read_fetch_data = 32'h00500093;
    tick(); tick();
    check("rst_instr",  o_instruction, 32'h0);
    check("rst_valid",  {31'b0, o_valid}, 32'h0);
    check("rst_rd",     {27'b0, o_rd}, 32'h0);
    check("rst_halted", {31'b0, o_halted}, 32'h0);

    // Decode table with stage disabled so the halt flag stays clear.
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_pc = 32'd5 + 32'(i) * 32'd3;
      i_read_fetch_data = vecs[i].data;
      #1;
      check($sformatf("v%0d_addr", i),  o_read_fetch_addr, 32'd5 + 32'(i) * 32'd3);
      check($sformatf("v%0d_instr", i), o_instruction, vecs[i].data);
      check($sformatf("v%0d_valid", i), {31'b0, o_valid}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d_itype", i), {29'b0, o_imm_type}, {29'b0, vecs[i].itype});
      check($sformatf("v%0d_imm", i),   o_imm, vecs[i].imm);
      check($sformatf("v%0d_rd", i),    {27'b0, o_rd}, {27'b0, vecs[i].rd});
      @(negedge clk);
    end
    check("tbl_halted", {31'b0, o_halted}, 32'h0);
    // Spot-check other fields on the store vector.
    i_read_fetch_data = 32'hFE20AC23; #1;
    check("sw_rs1", {27'b0, o_rs1}, 32'd1);
    check("sw_rs2", {27'b0, o_rs2}, 32'd2);
    check("sw_f3",  {29'b0, o_funct3}, 32'd2);
    check("sw_f7",  {25'b0, o_funct7}, 32'h7F);
    check("sw_op",  {25'b0, o_opcode}, 32'h23);

    // clk_en=0 with an invalid word leaves the flag clear.
    i_read_fetch_data = 32'h0;
    tick();
    check("noen_halted0", {31'b0, o_halted}, 32'h0);

    // Enabled zero word sets halt; it sticks through valid data.
    @(negedge clk); clk_en = 1'b1;
    tick();
    check("halt_set", {31'b0, o_halted}, 32'h1);
    @(negedge clk); i_read_fetch_data = 32'h00500093;
    tick(); tick();
    check("halt_sticky", {31'b0, o_halted}, 32'h1);
    @(negedge clk); clk_en = 1'b0; i_read_fetch_data = 32'h40001033;
    tick();
    check("noen_halted1", {31'b0, o_halted}, 32'h1);

    // Reset clears the flag even with clk_en low.
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid_instr", o_instruction, 32'h0);
    tick();
    check("rst_mid_halted", {31'b0, o_halted}, 32'h0);

    // Valid stream with enable does not set halt.
    @(negedge clk); rst = 1'b0; clk_en = 1'b1; i_read_fetch_data = 32'h800000EF;
    tick(); tick();
    check("valid_no_halt", {31'b0, o_halted}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
